// File: rtl/regwrite_arb.sv
// regwrite_arb: round-robin owner of the register file write port.
// Two writeback sources (ALU on port 0, LSU on port 1) compete for one
// registered write per cycle. A pending scoreboard marks registers that
// have a producer in flight so decode can stall on read-after-write hazards.
module regwrite_arb #(
  parameter int RADDRWIDTH = 3,
  parameter int REGWIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [RADDRWIDTH-1:0] req0_addr,
  input  logic [REGWIDTH-1:0]   req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [RADDRWIDTH-1:0] req1_addr,
  input  logic [REGWIDTH-1:0]   req1_data,
  input  logic                  iss_valid,
  input  logic [RADDRWIDTH-1:0] iss_addr,
  input  logic [RADDRWIDTH-1:0] chk_addr_a,
  input  logic [RADDRWIDTH-1:0] chk_addr_b,
  input  logic [RADDRWIDTH-1:0] chk_addr_c,
  output logic                  chk_busy_a,
  output logic                  chk_busy_b,
  output logic                  chk_busy_c,
  output logic                  we,
  output logic [RADDRWIDTH-1:0] waddr,
  output logic [REGWIDTH-1:0]   wdata
);

  localparam int NREGS = 1 << RADDRWIDTH;

  // last_grant_q = 1 means port 1 won most recently, so port 0 wins a tie
  logic                  last_grant_q;
  logic                  last_grant_d;
  logic                  we_q;
  logic [RADDRWIDTH-1:0] waddr_q;
  logic [REGWIDTH-1:0]   wdata_q;
  logic [NREGS-1:0]      pending_q;
  logic [NREGS-1:0]      pending_d;

  logic                  grant0;
  logic                  grant1;
  logic                  accept;
  logic [RADDRWIDTH-1:0] acc_addr;
  logic [REGWIDTH-1:0]   acc_data;

  // Round-robin grant; handshakes are suppressed while reset is held
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      grant0 = req0_valid && (!req1_valid || last_grant_q);
      grant1 = req1_valid && (!req0_valid || !last_grant_q);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 || grant1;

  // Select the winning request and remember who won for the next tie
  always_comb begin
    acc_addr     = req0_addr;
    acc_data     = req0_data;
    last_grant_d = last_grant_q;
    if (grant1) begin
      acc_addr     = req1_addr;
      acc_data     = req1_data;
      last_grant_d = 1'b1;
    end else if (grant0) begin
      last_grant_d = 1'b0;
    end
  end

  // Arbiter history register
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // Write stage: one-cycle registered write; r0 writes are swallowed here
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (accept && (acc_addr != '0)) begin
      we_q    <= 1'b1;
      waddr_q <= acc_addr;
      wdata_q <= acc_data;
    end else begin
      we_q    <= 1'b0;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

  // Scoreboard next state per register; an issue on the committing edge
  // wins because it names a newer producer. r0 never becomes pending.
  assign pending_d[0] = 1'b0;
  for (genvar gi = 1; gi < NREGS; gi++) begin : g_pend
    assign pending_d[gi] =
        (iss_valid && (iss_addr == RADDRWIDTH'(gi))) ||
        (pending_q[gi] && !(we_q && (waddr_q == RADDRWIDTH'(gi))));
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign chk_busy_a = pending_q[chk_addr_a];
  assign chk_busy_b = pending_q[chk_addr_b];
  assign chk_busy_c = pending_q[chk_addr_c];

endmodule

// File: tb/tb_regwrite_arb.sv
// tb_regwrite_arb: directed scenarios followed by random traffic, all
// checked against a cycle-level behavioural model of the write arbiter.
module tb_regwrite_arb;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          iss_valid;
  logic [AW-1:0] iss_addr;
  logic [AW-1:0] chk_addr_a, chk_addr_b, chk_addr_c;
  logic          chk_busy_a, chk_busy_b, chk_busy_c;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  regwrite_arb #(.RADDRWIDTH(AW), .REGWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b), .chk_addr_c(chk_addr_c),
    .chk_busy_a(chk_busy_a), .chk_busy_b(chk_busy_b), .chk_busy_c(chk_busy_c),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int      m_winner_last;     // port that won most recently
  bit      m_we;
  int      m_waddr;
  int      m_wdata;
  bit      m_pend [NR];
  bit      m_acc0, m_acc1;    // acceptances at the last edge

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
    iss_valid = 1'b0; iss_addr = '0;
  endtask

  // Which port the specification says wins this cycle (-1 for none)
  function automatic int exp_winner();
    if (rst) return -1;
    if (req0_valid && req1_valid) return (m_winner_last == 0) ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the rising edge
  task automatic tick(input string name);
    int w;
    int a;
    int d;
    @(negedge clk);
    w = exp_winner();
    check_val({name, ".ready0"}, 32'(req0_ready), 32'(w == 0));
    check_val({name, ".ready1"}, 32'(req1_ready), 32'(w == 1));
    check_val({name, ".we"}, 32'(we), 32'(m_we));
    check_val({name, ".waddr"}, 32'(waddr), 32'(m_waddr));
    check_val({name, ".wdata"}, 32'(wdata), 32'(m_wdata));
    check_val({name, ".busy_a"}, 32'(chk_busy_a), 32'(m_pend[chk_addr_a]));
    check_val({name, ".busy_b"}, 32'(chk_busy_b), 32'(m_pend[chk_addr_b]));
    check_val({name, ".busy_c"}, 32'(chk_busy_c), 32'(m_pend[chk_addr_c]));
    $display("[%0t] %s rst=%0b v=%0b%0b win=%0d we=%0b waddr=%0d wdata=%h busy=%0b%0b%0b",
             $time, name, rst, req0_valid, req1_valid, w, we, waddr, wdata,
             chk_busy_a, chk_busy_b, chk_busy_c);
    @(posedge clk);
    m_acc0 = (w == 0);
    m_acc1 = (w == 1);
    if (rst) begin
      m_winner_last = 1;
      m_we = 1'b0; m_waddr = 0; m_wdata = 0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
    end else begin
      // committing write retires its producer; a same-edge issue overrides it
      if (m_we) m_pend[m_waddr] = 1'b0;
      if (iss_valid && iss_addr != 0) m_pend[iss_addr] = 1'b1;
      if (w >= 0) begin
        m_winner_last = w;
        a = (w == 0) ? int'(req0_addr) : int'(req1_addr);
        d = (w == 0) ? int'(req0_data) : int'(req1_data);
        if (a != 0) begin
          m_we = 1'b1; m_waddr = a; m_wdata = d;
        end else begin
          m_we = 1'b0;
        end
      end else begin
        m_we = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    set_idle();
    chk_addr_a = 3'd5; chk_addr_b = 3'd4; chk_addr_c = 3'd0;
    rst = 1'b1;
    m_winner_last = 1; m_we = 0; m_waddr = 0; m_wdata = 0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    @(posedge clk); #1;

    // Reset held with both requesters valid: no handshake allowed
    req0_valid = 1; req0_addr = 3'd1; req0_data = 16'hA001;
    req1_valid = 1; req1_addr = 3'd2; req1_data = 16'hB002;
    tick("reset");
    check_val("reset.we_lit", 32'(we), 32'd0);
    rst = 1'b0;

    // Contention: grants must alternate 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      tick("contend");
      if (m_acc0) req0_data = req0_data + 16'h0010;
      if (m_acc1) req1_data = req1_data + 16'h0010;
    end
    set_idle();
    tick("contend_drain");
    tick("contend_idle");

    // Single request, literal expectations on the write
    req0_valid = 1; req0_addr = 3'd3; req0_data = 16'h1234;
    tick("single_req");
    set_idle();
    tick("single_we");
    check_val("single.waddr_lit", 32'(waddr), 32'd3);
    check_val("single.wdata_lit", 32'(wdata), 32'h1234);
    tick("single_off");

    // Scoreboard set then clear on commit
    iss_valid = 1; iss_addr = 3'd5;
    tick("sb_issue");
    set_idle();
    tick("sb_busy");
    check_val("sb.busy_lit", 32'(chk_busy_a), 32'd1);
    req1_valid = 1; req1_addr = 3'd5; req1_data = 16'h5555;
    tick("sb_accept");
    set_idle();
    tick("sb_commit");
    tick("sb_cleared");

    // Issue to the register being committed on the same edge: stays busy
    iss_valid = 1; iss_addr = 3'd5;
    tick("same_issue1");
    set_idle();
    req0_valid = 1; req0_addr = 3'd5; req0_data = 16'h0F0F;
    tick("same_accept");
    set_idle();
    iss_valid = 1; iss_addr = 3'd5;
    tick("same_commit_issue");
    set_idle();
    tick("same_after");
    check_val("same.busy_lit", 32'(chk_busy_a), 32'd1);

    // Issue to r0 and write to r0
    chk_addr_c = 3'd0;
    iss_valid = 1; iss_addr = 3'd0;
    req0_valid = 1; req0_addr = 3'd0; req0_data = 16'hDEAD;
    tick("r0_req");
    set_idle();
    tick("r0_after");
    check_val("r0.busy_lit", 32'(chk_busy_c), 32'd0);

    // Mid-operation reset drops the write, pending state and arbiter history
    iss_valid = 1; iss_addr = 3'd4;
    tick("mid_issue");
    set_idle();
    req1_valid = 1; req1_addr = 3'd6; req1_data = 16'h6666;
    tick("mid_prime");   // port 1 wins, so port 1 is now last winner
    set_idle();
    req0_valid = 1; req0_addr = 3'd4; req0_data = 16'h4444;
    tick("mid_accept");  // port 0 wins, history would now favour port 1
    set_idle();
    req1_valid = 1; req1_addr = 3'd7; req1_data = 16'h7777;
    req0_valid = 1; req0_addr = 3'd7; req0_data = 16'h7070;
    rst = 1'b1;
    tick("mid_rst");
    rst = 1'b0;
    tick("mid_tie");     // port 0 must win the tie after reset
    set_idle();

    // Random traffic; requesters hold addr/data until accepted
    for (int k = 0; k < 400; k++) begin
      if (!req0_valid || m_acc0) begin
        req0_valid = ($urandom_range(0, 99) < 60);
        req0_addr  = AW'($urandom);
        req0_data  = DW'($urandom);
      end
      if (!req1_valid || m_acc1) begin
        req1_valid = ($urandom_range(0, 99) < 60);
        req1_addr  = AW'($urandom);
        req1_data  = DW'($urandom);
      end
      iss_valid  = ($urandom_range(0, 99) < 40);
      iss_addr   = AW'($urandom);
      chk_addr_a = AW'($urandom);
      chk_addr_b = AW'($urandom);
      chk_addr_c = AW'($urandom);
      rst        = ($urandom_range(0, 99) < 2);
      tick("rand");
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
